// File: rtl/hls_loop_mon_pkg.sv
// Shared types for the HLS loop activity tracker: record kinds, module FSM states
// and the default counter width.
package hls_loop_mon_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    REC_NONE      = 2'd0,
    REC_MOD_DONE  = 2'd1,
    REC_LOOP_DONE = 2'd2
  } rec_kind_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mod_state_e;

endpackage

// File: rtl/hls_loop_activity_tracker_iter_ts_fifo.sv
// Circular timestamp FIFO for in-flight loop iterations. Push and pop may coincide
// at any occupancy; on empty the pushed value is forwarded straight to the head.
module iter_ts_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? din : mem[rd_ptr];

  // Push+pop on empty bypasses storage; push on full only lands if a pop frees the slot.
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || pop) && !(empty && pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hls_loop_activity_tracker.sv
// Passive tracker for one HLS kernel and its pipelined loop: cycle/event counters and
// latency records. Define LOOP_STALL_CNT_EN to enable the loop stall-cycle counter.
module hls_loop_activity_tracker
  import hls_loop_mon_pkg::*;
#(
  parameter int unsigned STATE_W  = 1,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned TS_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   mod_txn_cnt,
  output logic [CNT_W-1:0]   mod_last_lat,
  output logic [CNT_W-1:0]   mod_last_ii,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   iter_inflight,
  output logic [CNT_W-1:0]   iter_last_lat,
  output logic [CNT_W-1:0]   loop_txn_cnt,
  output logic               rec_valid,
  output logic [1:0]         rec_kind,
  output logic [CNT_W-1:0]   rec_lat,
  output logic [CNT_W-1:0]   rec_start,
  output logic [CNT_W-1:0]   stall_cycles
);

  mod_state_e       mod_state;
  logic [CNT_W-1:0] mod_start_ts;
  logic             mod_seen_start;
  logic             loop_active;
  logic [CNT_W-1:0] loop_start_ts;
  logic             hold_valid;
  logic [CNT_W-1:0] hold_lat;
  logic [CNT_W-1:0] hold_start;
  logic             ts_overflow;
  logic             ts_full;
  logic             ts_empty;
  logic [CNT_W-1:0] ts_head;

  logic istart, iend, quit, pop_hit;
  logic mod_done, mod_accept, loop_end, loop_accept;

  // ap_ready and loop_ready carry no information the tracker needs.
  logic unused_ready;
  assign unused_ready = ap_ready ^ loop_ready;

  assign istart  = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
  assign iend    = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
  assign quit    = (cur_state == quit_state) && quit_enable && !quit_block;
  assign pop_hit = iend && (!ts_empty || istart);

  assign mod_done    = (mod_state == BUSY) && ap_done && ap_continue;
  assign mod_accept  = ap_start && ((mod_state == IDLE) || mod_done);
  assign loop_end    = loop_active && ((loop_done && loop_continue) || (!quit_at_end && quit));
  assign loop_accept = loop_start && (!loop_active || loop_end);

  iter_ts_fifo #(.DEPTH(TS_DEPTH), .W(CNT_W)) u_ts_fifo (
    .clock (clock),
    .reset (reset),
    .push  (istart),
    .pop   (iend),
    .din   (cycle_cnt),
    .dout  (ts_head),
    .full  (ts_full),
    .empty (ts_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt      <= '0;
      iter_start_cnt <= '0;
      iter_end_cnt   <= '0;
      iter_inflight  <= '0;
      iter_last_lat  <= '0;
      ts_overflow    <= 1'b0;
    end else begin
      if (!finish) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (istart) iter_start_cnt <= iter_start_cnt + CNT_W'(1);
      if (iend)   iter_end_cnt   <= iter_end_cnt + CNT_W'(1);
      if (istart && !iend)
        iter_inflight <= iter_inflight + CNT_W'(1);
      else if (iend && !istart && (iter_inflight != '0))
        iter_inflight <= iter_inflight - CNT_W'(1);
      if (pop_hit) iter_last_lat <= cycle_cnt - ts_head;
      ts_overflow <= ts_overflow | (istart && ts_full && !iend);
    end
  end

  // Done retires before a same-cycle start is accepted, so both may fire together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mod_state      <= IDLE;
      mod_start_ts   <= '0;
      mod_seen_start <= 1'b0;
      mod_txn_cnt    <= '0;
      mod_last_lat   <= '0;
      mod_last_ii    <= '0;
    end else begin
      if (mod_done) begin
        mod_txn_cnt  <= mod_txn_cnt + CNT_W'(1);
        mod_last_lat <= cycle_cnt - mod_start_ts;
      end
      if (mod_accept) begin
        mod_state      <= BUSY;
        mod_start_ts   <= cycle_cnt;
        mod_seen_start <= 1'b1;
        if (mod_seen_start) mod_last_ii <= cycle_cnt - mod_start_ts;
      end else if (mod_done) begin
        mod_state <= IDLE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loop_active   <= 1'b0;
      loop_start_ts <= '0;
      loop_txn_cnt  <= '0;
      hold_valid    <= 1'b0;
      hold_lat      <= '0;
      hold_start    <= '0;
      rec_valid     <= 1'b0;
      rec_kind      <= REC_NONE;
      rec_lat       <= '0;
      rec_start     <= '0;
    end else begin
      if (loop_end) loop_txn_cnt <= loop_txn_cnt + CNT_W'(1);
      if (loop_accept) begin
        loop_active   <= 1'b1;
        loop_start_ts <= cycle_cnt;
      end else if (loop_end) begin
        loop_active <= 1'b0;
      end

      // A LOOP_DONE colliding with MOD_DONE waits one cycle in the hold slot.
      rec_valid <= 1'b0;
      if (mod_done) begin
        rec_valid <= 1'b1;
        rec_kind  <= REC_MOD_DONE;
        rec_lat   <= cycle_cnt - mod_start_ts;
        rec_start <= mod_start_ts;
        if (loop_end) begin
          hold_valid <= 1'b1;
          hold_lat   <= cycle_cnt - loop_start_ts;
          hold_start <= loop_start_ts;
        end
      end else if (hold_valid) begin
        rec_valid  <= 1'b1;
        rec_kind   <= REC_LOOP_DONE;
        rec_lat    <= hold_lat;
        rec_start  <= hold_start;
        hold_valid <= loop_end;
        if (loop_end) begin
          hold_lat   <= cycle_cnt - loop_start_ts;
          hold_start <= loop_start_ts;
        end
      end else if (loop_end) begin
        rec_valid <= 1'b1;
        rec_kind  <= REC_LOOP_DONE;
        rec_lat   <= cycle_cnt - loop_start_ts;
        rec_start <= loop_start_ts;
      end
    end
  end

`ifdef LOOP_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if ((cur_state == iter_start_state) && iter_start_enable && iter_start_block)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_loop_activity_tracker.sv
// Directed and randomized checks of hls_loop_activity_tracker against a cycle-level
// behavioural model (queue of iteration timestamps, pending record list).
module tb_hls_loop_activity_tracker;
  import hls_loop_mon_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset, finish;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic [31:0] cycle_cnt, mod_txn_cnt, mod_last_lat, mod_last_ii;
  logic [31:0] iter_start_cnt, iter_end_cnt, iter_inflight, iter_last_lat, loop_txn_cnt;
  logic        rec_valid;
  logic [1:0]  rec_kind;
  logic [31:0] rec_lat, rec_start, stall_cycles;

  always #5 clock = ~clock;

  hls_loop_activity_tracker #(.STATE_W(1), .CNT_W(32), .TS_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .cycle_cnt(cycle_cnt), .mod_txn_cnt(mod_txn_cnt), .mod_last_lat(mod_last_lat),
    .mod_last_ii(mod_last_ii), .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt),
    .iter_inflight(iter_inflight), .iter_last_lat(iter_last_lat), .loop_txn_cnt(loop_txn_cnt),
    .rec_valid(rec_valid), .rec_kind(rec_kind), .rec_lat(rec_lat), .rec_start(rec_start),
    .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad = 0;

  typedef struct { int unsigned lat; int unsigned st; } rec_t;

  int unsigned m_cyc, m_txn, m_lat, m_ii, m_start, m_is, m_ie, m_inf, m_ilat;
  int unsigned m_ltxn, m_lstart, m_stall, m_rlat, m_rst;
  int unsigned m_rkind;
  bit m_busy, m_have, m_lact, m_rv, m_ovf;
  int unsigned m_ts[$];
  rec_t m_pend[$];
  int unsigned peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_txn = 0; m_lat = 0; m_ii = 0; m_start = 0; m_is = 0; m_ie = 0;
    m_inf = 0; m_ilat = 0; m_ltxn = 0; m_lstart = 0; m_stall = 0; m_rlat = 0; m_rst = 0;
    m_rkind = 0; m_busy = 0; m_have = 0; m_lact = 0; m_rv = 0; m_ovf = 0;
    m_ts.delete(); m_pend.delete();
  endtask

  // Advance the reference model by one clock edge using the currently driven inputs.
  task automatic model_step();
    bit is, ie, qt, hm, hl;
    rec_t mr, lr, pr;
    int d;
    if (!reset) begin model_reset(); return; end
    is = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    ie = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    qt = (cur_state == quit_state) && quit_enable && !quit_block;
    hm = 0; hl = 0;
    if (m_busy && ap_done && ap_continue) begin
      hm = 1; m_txn++; m_lat = m_cyc - m_start;
      mr.lat = m_lat; mr.st = m_start; m_busy = 0;
    end
    if (!m_busy && ap_start) begin
      if (m_have) m_ii = m_cyc - m_start;
      m_start = m_cyc; m_have = 1; m_busy = 1;
    end
    if (m_lact && ((loop_done && loop_continue) || (!quit_at_end && qt))) begin
      hl = 1; m_ltxn++; lr.lat = m_cyc - m_lstart; lr.st = m_lstart; m_lact = 0;
    end
    if (!m_lact && loop_start) begin m_lact = 1; m_lstart = m_cyc; end
    m_rv = 0;
    if (hm) begin
      m_rv = 1; m_rkind = 1; m_rlat = mr.lat; m_rst = mr.st;
      if (hl) m_pend.push_back(lr);
    end else if (m_pend.size() > 0) begin
      pr = m_pend.pop_front();
      m_rv = 1; m_rkind = 2; m_rlat = pr.lat; m_rst = pr.st;
      if (hl) m_pend.push_back(lr);
    end else if (hl) begin
      m_rv = 1; m_rkind = 2; m_rlat = lr.lat; m_rst = lr.st;
    end
    if (is) m_is++;
    if (ie) m_ie++;
    d = int'(m_inf) + (is ? 1 : 0) - (ie ? 1 : 0);
    m_inf = (d < 0) ? 0 : d;
    if (is) m_ts.push_back(m_cyc);
    if (ie && m_ts.size() > 0) m_ilat = m_cyc - m_ts.pop_front();
    if (m_ts.size() > DEPTH) begin void'(m_ts.pop_back()); m_ovf = 1; end
`ifdef LOOP_STALL_CNT_EN
    if ((cur_state == iter_start_state) && iter_start_enable && iter_start_block) m_stall++;
`endif
    if (!finish) m_cyc++;
  endtask

  task automatic check_all();
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("mod_txn_cnt", mod_txn_cnt, m_txn);
    chk("mod_last_lat", mod_last_lat, m_lat);
    chk("mod_last_ii", mod_last_ii, m_ii);
    chk("iter_start_cnt", iter_start_cnt, m_is);
    chk("iter_end_cnt", iter_end_cnt, m_ie);
    chk("iter_inflight", iter_inflight, m_inf);
    chk("iter_last_lat", iter_last_lat, m_ilat);
    chk("loop_txn_cnt", loop_txn_cnt, m_ltxn);
    chk("rec_valid", 32'(rec_valid), 32'(m_rv));
    if (m_rv) begin
      chk("rec_kind", 32'(rec_kind), m_rkind);
      chk("rec_lat", rec_lat, m_rlat);
      chk("rec_start", rec_start, m_rst);
    end
    chk("stall_cycles", stall_cycles, m_stall);
    chk("overflow", 32'(dut.ts_overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
    if (iter_inflight > peak) peak = iter_inflight;
  endtask

  task automatic clear_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 1; iter_start_state = 1; iter_end_state = 1; quit_state = 0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    @(posedge clock);
    #1;
    check_all();
    reset = 1;
    peak = 0;
  endtask

  task automatic run_to(input int unsigned n);
    for (int k = 0; k < 2000 && m_cyc != n; k++) tick();
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    peak = 0;
    model_reset();

    // Module transaction: start at 5, done at 25.
    do_reset();
    run_to(5); ap_start = 1; tick(); ap_start = 0;
    run_to(25); ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    chk("t1_txn", mod_txn_cnt, 1);
    chk("t1_lat", mod_last_lat, 20);
    chk("t1_rec_valid", 32'(rec_valid), 1);
    chk("t1_rec_kind", 32'(rec_kind), 1);
    chk("t1_rec_start", rec_start, 5);
    tick();
    chk("t1_rec_pulse", 32'(rec_valid), 0);

    // Starts at 5 and 13, the second coinciding with done.
    do_reset();
    run_to(5); ap_start = 1; tick(); ap_start = 0;
    run_to(13); ap_start = 1; ap_done = 1; ap_continue = 1; tick();
    ap_start = 0; ap_done = 0; ap_continue = 0;
    chk("t2_ii", mod_last_ii, 8);
    chk("t2_lat", mod_last_lat, 8);
    run_to(20); ap_done = 1; ap_continue = 1; tick(); ap_done = 0; ap_continue = 0;
    chk("t2_lat2", mod_last_lat, 7);
    chk("t2_txn", mod_txn_cnt, 2);

    // Iterations start 10,11,12 and end 12,13,14; then a blocked start stage 20-22.
    do_reset();
    run_to(10); iter_start_enable = 1; tick(); tick();
    iter_end_enable = 1; tick();
    iter_start_enable = 0; tick(); tick(); iter_end_enable = 0;
    chk("t3_ilat", iter_last_lat, 2);
    chk("t3_peak", peak, 2);
    chk("t3_inflight", iter_inflight, 0);
    run_to(20); iter_start_enable = 1; iter_start_block = 1;
    tick(); tick(); tick();
    iter_start_enable = 0; iter_start_block = 0;
    chk("t4_istart", iter_start_cnt, 3);
`ifdef LOOP_STALL_CNT_EN
    chk("t4_stall", stall_cycles, 3);
`else
    chk("t4_stall", stall_cycles, 0);
`endif

    // Five pushes into a four-deep store, then six pops.
    do_reset();
    run_to(1); iter_start_enable = 1;
    for (int i = 0; i < 5; i++) tick();
    iter_start_enable = 0;
    chk("t5_istart", iter_start_cnt, 5);
    chk("t5_ovf", 32'(dut.ts_overflow), 1);
    iter_end_enable = 1;
    for (int i = 0; i < 6; i++) tick();
    iter_end_enable = 0;
    chk("t5_ilat", iter_last_lat, 5);
    chk("t5_iend", iter_end_cnt, 6);
    chk("t5_inflight", iter_inflight, 0);

    // Module and loop completion in the same cycle.
    do_reset();
    run_to(2); ap_start = 1; tick(); ap_start = 0;
    loop_start = 1; tick(); loop_start = 0;
    run_to(8);
    ap_done = 1; ap_continue = 1; loop_done = 1; loop_continue = 1; tick();
    ap_done = 0; ap_continue = 0; loop_done = 0; loop_continue = 0;
    chk("t6_kind0", 32'(rec_kind), 1);
    chk("t6_lat0", rec_lat, 6);
    tick();
    chk("t6_valid1", 32'(rec_valid), 1);
    chk("t6_kind1", 32'(rec_kind), 2);
    chk("t6_lat1", rec_lat, 5);
    chk("t6_start1", rec_start, 3);

    // Reset asserted while BUSY.
    do_reset();
    run_to(2); ap_start = 1; tick(); ap_start = 0;
    run_to(5); ap_done = 1; ap_continue = 1;
    reset = 0; #1; model_reset(); check_all();
    chk("t7_cyc", cycle_cnt, 0);
    tick(); tick();
    reset = 1; ap_done = 0; ap_continue = 0; tick();
    chk("t7_txn", mod_txn_cnt, 0);
    chk("t7_rec", 32'(rec_valid), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      finish            = ($urandom_range(0, 9) == 0);
      cur_state         = 1'($urandom_range(0, 1));
      iter_start_state  = 1'($urandom_range(0, 1));
      iter_end_state    = 1'($urandom_range(0, 1));
      quit_state        = 1'($urandom_range(0, 1));
      iter_start_enable = 1'($urandom_range(0, 1));
      iter_end_enable   = 1'($urandom_range(0, 1));
      quit_enable       = ($urandom_range(0, 7) == 0);
      iter_start_block  = ($urandom_range(0, 3) == 0);
      iter_end_block    = ($urandom_range(0, 3) == 0);
      quit_block        = ($urandom_range(0, 3) == 0);
      loop_start        = ($urandom_range(0, 3) == 0);
      loop_done         = ($urandom_range(0, 4) == 0);
      loop_continue     = ($urandom_range(0, 3) != 0);
      quit_at_end       = 1'($urandom_range(0, 1));
      ap_start          = ($urandom_range(0, 2) == 0);
      ap_done           = ($urandom_range(0, 4) == 0) && (m_pend.size() == 0);
      ap_continue       = ($urandom_range(0, 3) != 0);
      tick();
    end
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
